// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with write-to-read bypass and busy scoreboard
//
// NREGS x DATA_W register file sitting between decode and writeback.
// Decode reads two operands and reserves a destination on issue; writeback
// writes the result and releases the reservation. busy1/busy2 tell decode
// that an operand still has a producer in flight so it can stall.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   reg_write/waddr/wdata writeback port
//   raddr1/2, rdata1/2    combinational read ports with writeback bypass
//   busy1/2               operand at raddrN has a pending producer
//   rsv_valid/rsv_addr    reservation request from decode
//   rsv_ready             reservation can be accepted this cycle
//   flush                 synchronous clear of all reservations
//   pend_cnt              registered count of busy registers

module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy1,
  output logic              busy2,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ready,
  input  logic              flush,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic [ADDR_W:0]   pend_nxt;

  // Register 0 is hardwired when ZERO_REG is set.
  logic waddr_zero;
  logic raddr1_zero;
  logic raddr2_zero;
  logic rsv_zero;

  assign waddr_zero  = ZERO_REG && (waddr == '0);
  assign raddr1_zero = ZERO_REG && (raddr1 == '0);
  assign raddr2_zero = ZERO_REG && (raddr2 == '0);
  assign rsv_zero    = ZERO_REG && (rsv_addr == '0);

  // A write to the hardwired zero register is treated as no write at all,
  // so it neither bypasses nor releases anything.
  logic wr_act;
  assign wr_act = reg_write && !waddr_zero;

  logic wr_hit1;
  logic wr_hit2;
  logic wr_hit_rsv;

  assign wr_hit1    = wr_act && (waddr == raddr1);
  assign wr_hit2    = wr_act && (waddr == raddr2);
  assign wr_hit_rsv = wr_act && (waddr == rsv_addr);

  // ------------------------------------------------------------------
  // Read ports
  // ------------------------------------------------------------------
  always_comb begin
    rdata1 = regs[raddr1];
    if (wr_hit1) begin
      rdata1 = wdata;
    end
    if (raddr1_zero) begin
      rdata1 = '0;
    end
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if (wr_hit2) begin
      rdata2 = wdata;
    end
    if (raddr2_zero) begin
      rdata2 = '0;
    end
  end

  // An operand being written back this cycle is already available through
  // the bypass, so it is not reported busy.
  assign busy1 = busy[raddr1] && !wr_hit1 && !raddr1_zero;
  assign busy2 = busy[raddr2] && !wr_hit2 && !raddr2_zero;

  // ------------------------------------------------------------------
  // Reservation handshake
  // ------------------------------------------------------------------
  // A second producer on a still-pending register (WAW) is refused, but a
  // register whose producer retires this very cycle can be handed over.
  assign rsv_ready = !flush && (rsv_zero || !busy[rsv_addr] || wr_hit_rsv);

  logic rsv_acc;
  assign rsv_acc = rsv_valid && rsv_ready && !rsv_zero;

  // Bit transitions drive the counter; a same-cycle release and re-reserve of
  // one register leaves it busy and therefore changes nothing.
  logic set_bit;
  logic clr_bit;

  assign set_bit = rsv_acc && !busy[rsv_addr];
  assign clr_bit = wr_act && busy[waddr] && !(rsv_acc && (rsv_addr == waddr));

  always_comb begin
    busy_nxt = busy;
    if (wr_act) begin
      busy_nxt[waddr] = 1'b0;
    end
    if (rsv_acc) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
  end

  always_comb begin
    pend_nxt = pend_cnt + {{ADDR_W{1'b0}}, set_bit} - {{ADDR_W{1'b0}}, clr_bit};
    if (flush) begin
      pend_nxt = '0;
    end
  end

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_act) begin
      regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed scoreboard testbench for reg_file_sb

module tb_reg_file_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              reg_write;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              busy1;
  logic              busy2;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rsv_ready;
  logic              flush;
  logic [ADDR_W:0]   pend_cnt;

  reg_file_sb #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(1'b1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .reg_write(reg_write),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .busy1    (busy1),
    .busy2    (busy2),
    .rsv_valid(rsv_valid),
    .rsv_addr (rsv_addr),
    .rsv_ready(rsv_ready),
    .flush    (flush),
    .pend_cnt (pend_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];

  task automatic expect_val(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic idle();
    reg_write = 1'b0;
    waddr     = '0;
    wdata     = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    flush     = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // a few units later, well away from either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reserve(input int a);
    idle();
    rsv_valid = 1'b1;
    rsv_addr  = ADDR_W'(a);
    tick();
    idle();
  endtask

  task automatic write_reg(input int a, input logic [DATA_W-1:0] d);
    idle();
    reg_write = 1'b1;
    waddr     = ADDR_W'(a);
    wdata     = d;
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    raddr1  = 5'd5;
    raddr2  = 5'd7;
    reset_n = 1'b0;
    #3;

    // Reset state
    expect_val(0); chk("reset_pend_cnt", pend_cnt);
    expect_val(0); chk("reset_busy1", busy1);
    expect_val(0); chk("reset_busy2", busy2);
    expect_val(1); chk("reset_rsv_ready", rsv_ready);
    expect_val(0); chk("reset_rdata1", rdata1);
    flush = 1'b1;
    #1;
    expect_val(0); chk("reset_rsv_ready_flush", rsv_ready);
    flush = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Write then read register 5
    write_reg(5, 32'hDEADBEEF);
    raddr1 = 5'd5;
    #3;
    expect_val(32'hDEADBEEF); chk("read_r5", rdata1);

    // Register 0 is hardwired
    reg_write = 1'b1; waddr = 5'd0; wdata = 32'h1234; raddr1 = 5'd0;
    expect_val(0); #3; chk("r0_no_bypass", rdata1);
    tick();
    idle();
    #3;
    expect_val(0); chk("r0_read", rdata1);
    expect_val(0); chk("r0_busy", busy1);

    // Bypass on port 2 while regs[7] still holds the old value
    write_reg(7, 32'h11111111);
    reg_write = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr2 = 5'd7;
    expect_val(32'hA5A5A5A5); expect_val(32'h11111111);
    #3;
    chk("bypass_rdata2", rdata2);
    chk("bypass_old_r7", dut.regs[7]);
    tick();
    idle();
    #3;
    expect_val(32'hA5A5A5A5); chk("after_bypass_r7", rdata2);

    // Reserve register 3
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    expect_val(1); #3; chk("rsv3_ready", rsv_ready);
    tick();
    idle();
    raddr1 = 5'd3;
    #3;
    expect_val(1); chk("rsv3_pend", pend_cnt);
    expect_val(1); chk("rsv3_busy1", busy1);
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    #1;
    expect_val(0); chk("rsv3_waw_refused", rsv_ready);
    rsv_valid = 1'b0;
    reg_write = 1'b1; waddr = 5'd3; wdata = 32'h55;
    #1;
    expect_val(0);     chk("wb3_busy1_same_cycle", busy1);
    expect_val(32'h55); chk("wb3_rdata1", rdata1);
    tick();
    idle();
    #3;
    expect_val(0); chk("wb3_pend", pend_cnt);
    expect_val(0); chk("wb3_busy1", busy1);

    // Same-cycle writeback and re-reserve of register 4
    reserve(4);
    reg_write = 1'b1; waddr = 5'd4; wdata = 32'hCAFE0004;
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    expect_val(1); #3; chk("wb_rsv4_ready", rsv_ready);
    tick();
    idle();
    raddr1 = 5'd4;
    #3;
    expect_val(1);            chk("wb_rsv4_busy", busy1);
    expect_val(1);            chk("wb_rsv4_pend", pend_cnt);
    expect_val(32'hCAFE0004); chk("wb_rsv4_data", rdata1);
    write_reg(4, 32'hCAFE0005);
    #3;
    expect_val(0); chk("rel4_pend", pend_cnt);

    // Reserving register 0 is accepted but has no effect
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    expect_val(1); #3; chk("rsv0_ready", rsv_ready);
    tick();
    idle();
    #3;
    expect_val(0); chk("rsv0_pend", pend_cnt);

    // Flush with a concurrent reserve and write
    reserve(1);
    reserve(2);
    reserve(9);
    #3;
    expect_val(3); chk("three_pend", pend_cnt);
    flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 5'd10;
    reg_write = 1'b1; waddr = 5'd2; wdata = 32'h77;
    #1;
    expect_val(0); chk("flush_rsv_ready", rsv_ready);
    tick();
    idle();
    #3;
    expect_val(0); chk("flush_pend", pend_cnt);
    for (int i = 0; i < 32; i++) begin
      raddr1 = ADDR_W'(i);
      #1;
      expect_val(0);
      chk($sformatf("flush_busy_r%0d", i), busy1);
    end
    raddr1 = 5'd2;
    #1;
    expect_val(32'h77); chk("flush_write_r2", rdata1);

    // Asynchronous reset between edges
    reserve(6);
    reserve(8);
    raddr1 = 5'd6; raddr2 = 5'd5;
    #2;
    expect_val(2);            chk("pre_reset_pend", pend_cnt);
    expect_val(32'hDEADBEEF); chk("pre_reset_r5", rdata2);
    reset_n = 1'b0;
    #1;
    expect_val(0); chk("async_reset_pend", pend_cnt);
    expect_val(0); chk("async_reset_busy1", busy1);
    expect_val(0); chk("async_reset_rdata2", rdata2);
    raddr2 = 5'd2;
    #1;
    expect_val(0); chk("async_reset_r2", rdata2);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected values left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the integer register file: NREGS x DATA_W storage with two combinational read ports, one write port, write-to-read bypass and a per-register busy scoreboard. The decode stage reserves a destination on issue. Writeback clears the reservation. Operand-hazard flags go back to decode so it can stall. It sits between decode (reads, reservations) and writeback (writes) in the core pipeline.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; NREGS = 2**ADDR_W
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- reg_write  in  1  writeback enable
- waddr  in  ADDR_W  writeback index
- wdata  in  DATA_W  writeback data
- raddr1, raddr2  in  ADDR_W  read indices
- rdata1, rdata2  out  DATA_W  read data, combinational
- busy1, busy2  out  1  operand at raddrN still has a pending producer
- rsv_valid  in  1  request to mark rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- rsv_ready  out  1  reservation can be accepted this cycle
- flush  in  1  synchronous clear of all reservations
- pend_cnt  out  ADDR_W+1  number of busy registers, registered

## Operation
- State:
  - regs[NREGS] of DATA_W
  - busy[NREGS] bits
  - pend_cnt register
- Reset (reset_n low, async): all regs = 0, all busy = 0, pend_cnt = 0.
- After reset the outputs are:
  - rdata1/rdata2 = 0 for any address (bypass aside)
  - busy1/busy2 = 0
  - rsv_ready = 1 unless flush is high
- Write:
  - Condition: reg_write high and not (ZERO_REG and waddr == 0).
  - regs[waddr] <= wdata.
  - busy[waddr] <= 0, unless re-reserved in the same cycle.
  - Writing a non-busy register is legal: data is updated, busy and pend_cnt are unchanged.
- Read port N:
  - If ZERO_REG and raddrN == 0: rdataN = 0.
  - Else if a write is active and waddr == raddrN: rdataN = wdata (bypass).
  - Else: rdataN = regs[raddrN].
- busyN = busy[raddrN] and not (active write to raddrN). Forced 0 for register 0 when ZERO_REG.
- rsv_ready = not flush and (not busy[rsv_addr] or active write to rsv_addr).
  - A WAW reservation on a still-pending register is refused.
  - A reservation on a register being written back this cycle is accepted.
  - Reserving register 0 with ZERO_REG: rsv_ready = not flush, and acceptance has no effect.
- Accept (rsv_valid and rsv_ready, non-zero register): busy[rsv_addr] <= 1.
- Same-cycle write and reserve on the same register: the write updates data and busy stays 1, held by the new producer.
- Flush: all busy <= 0 and pend_cnt <= 0. Any write in the same cycle still updates regs. No reservation is accepted.
- pend_cnt next value = pend_cnt + (bit set 0->1) - (bit cleared 1->0). It always equals the popcount of busy and never wraps, since the maximum is NREGS, or NREGS-1 with ZERO_REG.

## Timing
- Reads, busyN and rsv_ready are purely combinational from inputs and state; zero-cycle latency.
- Writes, busy updates and pend_cnt take effect at the rising clk edge and are visible the following cycle. The bypass makes write data visible on the read ports in the same cycle.
- Priority within one edge:
  1. reset_n
  2. flush, for busy and pend_cnt
  3. reserve-set over write-clear on the same register
- Asserting reset_n mid-operation discards all data and reservations immediately, without waiting for a clock edge.

## Test plan
- Reset, then write 0xDEADBEEF to register 5. Read register 5 next cycle -> rdata1 = 0xDEADBEEF. Read register 0 after writing 0x1234 to it -> rdata = 0, busy = 0.
- Bypass: same cycle reg_write=1, waddr=7, wdata=0xA5A5A5A5, raddr2=7 -> rdata2 = 0xA5A5A5A5 while regs[7] still holds its old value.
- Reserve register 3 -> pend_cnt = 1 next cycle.
  - raddr1=3 -> busy1 = 1.
  - A second reserve of register 3 -> rsv_ready = 0.
  - Writeback to register 3 with 0x55 -> busy1 = 0 in that same cycle, rdata1 = 0x55, and pend_cnt = 0 next cycle.
- Same cycle: writeback to register 4 (busy) and reserve register 4 -> rsv_ready = 1; next cycle busy[4] = 1, pend_cnt unchanged, regs[4] = wdata.
- Reserve registers 1, 2 and 9 (pend_cnt = 3). Then flush together with rsv_valid for register 10 and a write of 0x77 to register 2 -> rsv_ready = 0. Next cycle: pend_cnt = 0, all busy = 0, regs[2] = 0x77.
- Assert reset_n low between clock edges with pend_cnt = 2 -> pend_cnt = 0, busy outputs = 0 and reads = 0 immediately.
